// File: rtl/tiny_soc_mem_arbiter.sv
// Two-port round-robin arbiter in front of the tiny SoC's single-port 64-bit SRAM.
// Decodes the memory window, flags out-of-range accesses and returns responses one cycle after grant.
module tiny_soc_mem_arbiter #(
    parameter int unsigned              NumWords     = 1 << 20,
    parameter int unsigned              AddrWidth    = 32,
    parameter int unsigned              DataWidth    = 64,
    parameter logic [AddrWidth-1:0]     MemBase      = 32'h8000_0000,
    parameter int unsigned              StrbWidth    = DataWidth >> 3,
    parameter int unsigned              WordIdxWidth = $clog2(NumWords)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    p0_req_i,
    output logic                    p0_gnt_o,
    input  logic                    p0_we_i,
    input  logic [AddrWidth-1:0]    p0_addr_i,
    input  logic [StrbWidth-1:0]    p0_strb_i,
    input  logic [DataWidth-1:0]    p0_wdata_i,
    output logic                    p0_rvalid_o,
    output logic [DataWidth-1:0]    p0_rdata_o,
    output logic                    p0_err_o,

    input  logic                    p1_req_i,
    output logic                    p1_gnt_o,
    input  logic                    p1_we_i,
    input  logic [AddrWidth-1:0]    p1_addr_i,
    input  logic [StrbWidth-1:0]    p1_strb_i,
    input  logic [DataWidth-1:0]    p1_wdata_i,
    output logic                    p1_rvalid_o,
    output logic [DataWidth-1:0]    p1_rdata_o,
    output logic                    p1_err_o,

    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [WordIdxWidth-1:0] sram_addr_o,
    output logic [StrbWidth-1:0]    sram_strb_o,
    output logic [DataWidth-1:0]    sram_wdata_o,
    input  logic [DataWidth-1:0]    sram_rdata_i,

    output logic [31:0]             conflict_cnt_o
);

    // Window limit is computed at 64 bits so the upper bound cannot wrap.
    localparam logic [63:0] MemLo = 64'(MemBase);
    localparam logic [63:0] MemHi = 64'(MemBase) + 64'(NumWords) * 64'd8;

    logic        rr_q, rr_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_port_q, resp_port_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_we_q, resp_we_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    logic                    gnt0, gnt1, anyGnt, inRange, respLive;
    logic                    selWe;
    logic [AddrWidth-1:0]    selAddr, offset;
    logic [StrbWidth-1:0]    selStrb;
    logic [DataWidth-1:0]    selWdata, respData;

    always_comb begin
        gnt0     = !rst_i && p0_req_i && (!p1_req_i || !rr_q);
        gnt1     = !rst_i && p1_req_i && (!p0_req_i ||  rr_q);
        anyGnt   = gnt0 || gnt1;

        selWe    = gnt1 ? p1_we_i    : p0_we_i;
        selAddr  = gnt1 ? p1_addr_i  : p0_addr_i;
        selStrb  = gnt1 ? p1_strb_i  : p0_strb_i;
        selWdata = gnt1 ? p1_wdata_i : p0_wdata_i;

        inRange  = (64'(selAddr) >= MemLo) && (64'(selAddr) < MemHi);
        offset   = selAddr - MemBase;

        sram_req_o   = anyGnt && inRange;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_strb_o  = '0;
        sram_wdata_o = '0;
        if (sram_req_o) begin
            sram_we_o    = selWe;
            sram_addr_o  = WordIdxWidth'(offset >> 3);
            sram_strb_o  = selStrb;
            sram_wdata_o = selWdata;
        end
    end

    assign p0_gnt_o = gnt0;
    assign p1_gnt_o = gnt1;

    // Next-state for the tie-break pointer, response pipeline and contention counter.
    always_comb begin
        rr_d = rr_q;
        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end

        resp_valid_d = anyGnt;
        resp_port_d  = gnt1;
        resp_err_d   = anyGnt && !inRange;
        resp_we_d    = anyGnt && selWe;

        conflict_cnt_d = conflict_cnt_q;
        if (p0_req_i && p1_req_i && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q           <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_port_q    <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_we_q      <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            rr_q           <= rr_d;
            resp_valid_q   <= resp_valid_d;
            resp_port_q    <= resp_port_d;
            resp_err_q     <= resp_err_d;
            resp_we_q      <= resp_we_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Gating with rst_i drops a response that is in flight when reset arrives.
    always_comb begin
        respLive = resp_valid_q && !rst_i;
        respData = (respLive && !resp_err_q && !resp_we_q) ? sram_rdata_i : '0;

        p0_rvalid_o = respLive && !resp_port_q;
        p1_rvalid_o = respLive &&  resp_port_q;
        p0_rdata_o  = p0_rvalid_o ? respData : '0;
        p1_rdata_o  = p1_rvalid_o ? respData : '0;
        p0_err_o    = p0_rvalid_o && resp_err_q;
        p1_err_o    = p1_rvalid_o && resp_err_q;
    end

    assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_tiny_soc_mem_arbiter.sv
// Directed bench for tiny_soc_mem_arbiter: per-cycle grant/SRAM checks plus a
// response scoreboard drained by an independent monitor.
module tb_tiny_soc_mem_arbiter;

    typedef struct packed {
        logic        port;
        logic [63:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0Req, p0Gnt, p0We, p0Rvalid, p0Err;
    logic [31:0] p0Addr;
    logic [7:0]  p0Strb;
    logic [63:0] p0Wdata, p0Rdata;
    logic        p1Req, p1Gnt, p1We, p1Rvalid, p1Err;
    logic [31:0] p1Addr;
    logic [7:0]  p1Strb;
    logic [63:0] p1Wdata, p1Rdata;
    logic        sramReq, sramWe;
    logic [19:0] sramAddr;
    logic [7:0]  sramStrb;
    logic [63:0] sramWdata, sramRdata;
    logic [31:0] conflictCnt;

    int    checks = 0;
    int    errors = 0;
    resp_t expQ[$];

    logic [63:0] mem [logic [19:0]];
    logic [63:0] wordTmp;

    localparam logic [63:0] WORD2 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] WORD1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] WTOP  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] MERGE = 64'hFFFF_FFFF_3333_4444;

    tiny_soc_mem_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .p0_req_i       (p0Req),
        .p0_gnt_o       (p0Gnt),
        .p0_we_i        (p0We),
        .p0_addr_i      (p0Addr),
        .p0_strb_i      (p0Strb),
        .p0_wdata_i     (p0Wdata),
        .p0_rvalid_o    (p0Rvalid),
        .p0_rdata_o     (p0Rdata),
        .p0_err_o       (p0Err),
        .p1_req_i       (p1Req),
        .p1_gnt_o       (p1Gnt),
        .p1_we_i        (p1We),
        .p1_addr_i      (p1Addr),
        .p1_strb_i      (p1Strb),
        .p1_wdata_i     (p1Wdata),
        .p1_rvalid_o    (p1Rvalid),
        .p1_rdata_o     (p1Rdata),
        .p1_err_o       (p1Err),
        .sram_req_o     (sramReq),
        .sram_we_o      (sramWe),
        .sram_addr_o    (sramAddr),
        .sram_strb_o    (sramStrb),
        .sram_wdata_o   (sramWdata),
        .sram_rdata_i   (sramRdata),
        .conflict_cnt_o (conflictCnt)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: byte-masked writes, reads return one cycle after the request.
    always @(posedge clk) begin
        if (sramReq) begin
            if (sramWe) begin
                wordTmp = mem.exists(sramAddr) ? mem[sramAddr] : 64'd0;
                for (int b = 0; b < 8; b++) begin
                    if (sramStrb[b]) wordTmp[b*8 +: 8] = sramWdata[b*8 +: 8];
                end
                mem[sramAddr] = wordTmp;
            end else begin
                sramRdata <= mem.exists(sramAddr) ? mem[sramAddr] : 64'd0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setP0(input logic req, input logic we, input logic [31:0] addr,
                         input logic [7:0] strb, input logic [63:0] wdata);
        p0Req = req; p0We = we; p0Addr = addr; p0Strb = strb; p0Wdata = wdata;
    endtask

    task automatic setP1(input logic req, input logic we, input logic [31:0] addr,
                         input logic [7:0] strb, input logic [63:0] wdata);
        p1Req = req; p1We = we; p1Addr = addr; p1Strb = strb; p1Wdata = wdata;
    endtask

    // One clock of held inputs: check grant/SRAM side mid-cycle, queue the response due next cycle.
    task automatic applyStimulus(input string name, input logic eg0, input logic eg1,
                                 input logic eReq, input logic eWe, input logic [19:0] eAddr,
                                 input logic [7:0] eStrb, input logic [63:0] eWdata,
                                 input logic push, input logic rPort, input logic [63:0] rData,
                                 input logic rErr);
        resp_t r;
        @(negedge clk);
        checkOutput({name, ".gnt0"},  64'(p0Gnt),     64'(eg0));
        checkOutput({name, ".gnt1"},  64'(p1Gnt),     64'(eg1));
        checkOutput({name, ".req"},   64'(sramReq),   64'(eReq));
        checkOutput({name, ".we"},    64'(sramWe),    64'(eWe));
        checkOutput({name, ".addr"},  64'(sramAddr),  64'(eAddr));
        checkOutput({name, ".strb"},  64'(sramStrb),  64'(eStrb));
        checkOutput({name, ".wdata"}, sramWdata,      eWdata);
        if (push) begin
            r.port = rPort; r.data = rData; r.err = rErr;
            expQ.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input string name);
        setP0(0, 0, 32'd0, 8'd0, 64'd0);
        setP1(0, 0, 32'd0, 8'd0, 64'd0);
        applyStimulus(name, 0, 0, 0, 0, 20'd0, 8'd0, 64'd0, 0, 0, 64'd0, 0);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every response the DUT presents must match the oldest queued expectation.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (p0Rvalid && p1Rvalid) begin
                checks++; errors++;
                $display("[TB] FAIL dual_rvalid: got both rvalid expected at most one");
            end else if (p0Rvalid || p1Rvalid) begin
                if (expQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_resp: got rvalid on port %0d expected none", p1Rvalid);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resp.port", 64'(p1Rvalid), 64'(e.port));
                    checkOutput("resp.data", p1Rvalid ? p1Rdata : p0Rdata, e.data);
                    checkOutput("resp.err",  64'(p1Rvalid ? p1Err : p0Err), 64'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mem[20'd2]     = WORD2;
        mem[20'd1]     = WORD1;
        mem[20'hFFFFF] = WTOP;
        sramRdata = 64'd0;
        rst = 1'b1;
        setP1(0, 0, 32'd0, 8'd0, 64'd0);
        setP0(1, 0, 32'h8000_0010, 8'hFF, 64'd0);

        // A request during reset must not be granted.
        @(negedge clk);
        checkOutput("rst.gnt0",   64'(p0Gnt),    64'd0);
        checkOutput("rst.sreq",   64'(sramReq),  64'd0);
        checkOutput("rst.rvalid", 64'(p0Rvalid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("rst.cnt", 64'(conflictCnt), 64'd0);
        rst = 1'b0;

        applyStimulus("single_rd", 1, 0, 1, 0, 20'd2, 8'hFF, 64'd0, 1, 0, WORD2, 0);
        idleCycle("idle0");

        resetDut();
        setP0(1, 0, 32'h8000_0010, 8'hFF, 64'd0);
        setP1(1, 0, 32'h8000_0008, 8'hFF, 64'd0);
        applyStimulus("conf0", 1, 0, 1, 0, 20'd2, 8'hFF, 64'd0, 1, 0, WORD2, 0);
        applyStimulus("conf1", 0, 1, 1, 0, 20'd1, 8'hFF, 64'd0, 1, 1, WORD1, 0);
        applyStimulus("conf2", 1, 0, 1, 0, 20'd2, 8'hFF, 64'd0, 1, 0, WORD2, 0);
        applyStimulus("conf3", 0, 1, 1, 0, 20'd1, 8'hFF, 64'd0, 1, 1, WORD1, 0);
        idleCycle("idle1");
        checkOutput("conf.cnt", 64'(conflictCnt), 64'd4);

        setP1(1, 1, 32'h7FFF_FFF8, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
        applyStimulus("oor_lo", 0, 1, 0, 0, 20'd0, 8'd0, 64'd0, 1, 1, 64'd0, 1);
        setP1(1, 1, 32'h8080_0000, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA);
        applyStimulus("oor_hi", 0, 1, 0, 0, 20'd0, 8'd0, 64'd0, 1, 1, 64'd0, 1);
        setP1(1, 0, 32'h807F_FFF8, 8'hFF, 64'd0);
        applyStimulus("top_rd", 0, 1, 1, 0, 20'hFFFFF, 8'hFF, 64'd0, 1, 1, WTOP, 0);

        setP1(1, 1, 32'h8000_0008, 8'h0F, 64'h1111_2222_3333_4444);
        applyStimulus("wr", 0, 1, 1, 1, 20'd1, 8'h0F, 64'h1111_2222_3333_4444, 1, 1, 64'd0, 0);
        setP1(0, 0, 32'd0, 8'd0, 64'd0);
        setP0(1, 0, 32'h8000_000D, 8'hFF, 64'd0);
        applyStimulus("rd_merge", 1, 0, 1, 0, 20'd1, 8'hFF, 64'd0, 1, 0, MERGE, 0);
        setP0(1, 1, 32'h8000_0008, 8'h00, 64'h5555_5555_5555_5555);
        applyStimulus("wr_strb0", 1, 0, 1, 1, 20'd1, 8'h00, 64'h5555_5555_5555_5555, 1, 0, 64'd0, 0);
        setP0(1, 0, 32'h8000_0008, 8'hFF, 64'd0);
        applyStimulus("rd_strb0", 1, 0, 1, 0, 20'd1, 8'hFF, 64'd0, 1, 0, MERGE, 0);
        idleCycle("idle2");

        // Granted read whose response cycle coincides with reset: nothing queued, so any rvalid fails.
        setP0(1, 0, 32'h8000_0010, 8'hFF, 64'd0);
        applyStimulus("pre_rst", 1, 0, 1, 0, 20'd2, 8'hFF, 64'd0, 0, 0, 64'd0, 0);
        setP0(0, 0, 32'd0, 8'd0, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst.rvalid", 64'(p0Rvalid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst.cnt", 64'(conflictCnt), 64'd0);
        setP0(1, 0, 32'h8000_0010, 8'hFF, 64'd0);
        setP1(1, 0, 32'h8000_0008, 8'hFF, 64'd0);
        applyStimulus("rst_rr", 1, 0, 1, 0, 20'd2, 8'hFF, 64'd0, 1, 0, WORD2, 0);
        idleCycle("idle3");

        force dut.conflict_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.conflict_cnt_q;
        setP0(1, 0, 32'h8000_0010, 8'hFF, 64'd0);
        setP1(1, 0, 32'h807F_FFF8, 8'hFF, 64'd0);
        applyStimulus("sat0", 0, 1, 1, 0, 20'hFFFFF, 8'hFF, 64'd0, 1, 1, WTOP, 0);
        applyStimulus("sat1", 1, 0, 1, 0, 20'd2,     8'hFF, 64'd0, 1, 0, WORD2, 0);
        applyStimulus("sat2", 0, 1, 1, 0, 20'hFFFFF, 8'hFF, 64'd0, 1, 1, WTOP, 0);
        idleCycle("idle4");
        checkOutput("sat.cnt", 64'(conflictCnt), 64'hFFFF_FFFF);

        idleCycle("idle5");
        checkOutput("sb_empty", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tiny_soc_mem_arbiter.md
Name: tiny_soc_mem_arbiter

Overview:
Shares the tiny SoC's single-port 64-bit main-memory SRAM between two OBI-style requesters. Port 0 is the core memory port (mem_req/we/addr/strb/data from the core wrapper). Port 1 is the testbench/fuzz program loader. The block performs round-robin arbitration, address decode against the memory window, out-of-range error responses, response routing with fixed one-cycle latency, and a saturating contention counter for coverage and debug.

Parameters:
NumWords, 1<<20, SRAM depth in 64-bit words; power of two.
AddrWidth, 32, requester byte-address width.
DataWidth, 64, data width; fixed at 64.
MemBase, 32'h8000_0000, byte address of SRAM word 0.
StrbWidth, DataWidth>>3, byte-strobe width (8).
WordIdxWidth, $clog2(NumWords), SRAM word-index width.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous active-high reset.
p0_req_i  in  1  port 0 request.
p0_gnt_o  out  1  port 0 grant (combinational).
p0_we_i  in  1  port 0 write enable.
p0_addr_i  in  AddrWidth  port 0 byte address.
p0_strb_i  in  StrbWidth  port 0 byte strobes.
p0_wdata_i  in  DataWidth  port 0 write data.
p0_rvalid_o  out  1  port 0 response valid.
p0_rdata_o  out  DataWidth  port 0 read data.
p0_err_o  out  1  port 0 response error (out of range).
p1_*  same set of signals as port 0, for port 1.
sram_req_o  out  1  SRAM access enable.
sram_we_o  out  1  SRAM write enable.
sram_addr_o  out  WordIdxWidth  SRAM word index.
sram_strb_o  out  StrbWidth  SRAM byte enables.
sram_wdata_o  out  DataWidth  SRAM write data.
sram_rdata_i  in  DataWidth  SRAM read data, valid 1 cycle after sram_req_o.
conflict_cnt_o  out  32  saturating count of cycles with both requests asserted.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - Round-robin pointer rr_q is set to 0 (port 0 wins the next conflict).
  - Response pipeline (resp_valid_q, resp_port_q, resp_err_q, resp_we_q) and conflict_cnt_o are cleared.
  - While rst_i=1: both gnt=0, sram_req_o=0, both rvalid=0, both rdata=0, both err=0.
  - A response pending when reset asserts is dropped; it is never delivered.
- Arbitration (combinational, same cycle as req):
  - Only one requester active: that requester is granted.
  - Both active: the port selected by rr_q is granted.
  - On any grant, rr_q <= granted port ^ 1 (the winner loses the next tie).
  - Never more than one gnt per cycle.
  - A requester holds req and all of its fields stable until granted. The arbiter does not check this.
- Decode:
  - In range when MemBase <= addr < MemBase + NumWords*8. Compare at full width; no wrap-around.
  - sram_addr_o = (addr - MemBase) >> 3. addr[2:0] is ignored and strobes are passed through unchanged.
- Granted in-range access:
  - sram_req_o=1; sram_we/strb/wdata/addr are driven from the winner in the same cycle.
  - A write with strb=0 still issues the access and modifies no bytes.
- Granted out-of-range access:
  - sram_req_o=0.
  - The response is flagged err.
- Response (exactly 1 cycle after grant, reads and writes alike):
  - Only the granted port sees rvalid=1.
  - rdata = sram_rdata_i for an in-range read; 0 for writes and errors.
  - err = 1 only for out-of-range.
  - Back-to-back grants give back-to-back responses. No buffering is needed because latency is fixed and rvalid has no ready.
- When sram_req_o=0, sram_we_o/strb/addr/wdata are driven to 0.
- conflict_cnt_o increments each non-reset cycle with p0_req_i & p1_req_i, and saturates at 32'hFFFF_FFFF.

Test Plan:
- Single read: after reset, p0 reads 0x8000_0010 while the SRAM holds 0xDEAD_BEEF_0123_4567 at word 2 -> same cycle p0_gnt=1, sram_addr=2, sram_we=0; next cycle p0_rvalid=1, rdata=0xDEAD_BEEF_0123_4567, err=0; p1_rvalid=0.
- Conflict round-robin: p0 and p1 both request continuously for 4 cycles -> grants p0,p1,p0,p1; responses follow one cycle later to the matching port; conflict_cnt_o=4.
- Out of range: p1 writes 0x7FFF_FFF8, then p1 writes MemBase+NumWords*8 -> sram_req_o=0 both times; each next cycle p1_rvalid=1, err=1, rdata=0.
- Write then read: p1 writes 0x8000_0008, strb=0x0F, wdata=0x1111_2222_3333_4444 over 0xFFFF_FFFF_FFFF_FFFF -> sram_strb=0x0F; a following p0 read of word 1 returns 0xFFFF_FFFF_3333_4444.
- Reset mid-operation: grant a p0 read, assert rst_i on the next edge -> no p0_rvalid; rr_q=0, so the next conflict grants p0; conflict_cnt_o=0.
- Saturation: preload conflict_cnt to 0xFFFF_FFFE by force, apply 3 conflict cycles -> counter holds 0xFFFF_FFFF.
